// File: rtl/canal_signal_lights.sv
`default_nettype none
// ============================================================================
// Module   : canal_signal_lights
// Brief    : Multi-channel request-switch qualifier with lit indicator, ack,
//            optional blink and lowest-index grant arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module canal_signal_lights #(
    parameter int CHANNELS   = 2,
    parameter int HOLD       = 16,
    parameter int BLINK_EN   = 0,
    parameter int BLINK_HALF = 8,
    localparam int CNT_W     = $clog2(HOLD + 1),
    localparam int IDX_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] sw,
    input  logic [CHANNELS-1:0] ack,
    output logic [CHANNELS-1:0] light,
    output logic [CHANNELS-1:0] pending,
    output logic                grant_valid,
    output logic [IDX_W-1:0]    grant_idx
);

    localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_QUAL  = 2'd1;
    localparam logic [1:0] ST_LIT   = 2'd2;
    localparam logic [1:0] ST_ACKED = 2'd3;

    localparam logic [CNT_W-1:0] c_hold_m1 = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
    localparam logic [BLK_W-1:0] c_blk_max = BLK_W'(BLINK_HALF - 1);

    logic [BLK_W-1:0] r_blk_cnt;
    logic             r_phase;
    logic             w_blink_gate;

    // Shared free-running blink timebase so all lit channels flash together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blk_cnt <= '0;
            r_phase   <= 1'b1;
        end else if (r_blk_cnt == c_blk_max) begin
            r_blk_cnt <= '0;
            r_phase   <= ~r_phase;
        end else begin
            r_blk_cnt <= r_blk_cnt + BLK_W'(1);
        end
    end

    assign w_blink_gate = (BLINK_EN != 0) ? r_phase : 1'b1;

    generate
        for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
            logic [1:0]       r_state;
            logic [CNT_W-1:0] r_cnt;

            // A released switch wins over everything, including ack and count.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end else if (!sw[ch]) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (HOLD == 1) begin
                                r_state <= ST_LIT;
                            end else begin
                                r_state <= ST_QUAL;
                                r_cnt   <= c_hold_m1;
                            end
                        end
                        ST_QUAL: begin
                            if (r_cnt == c_one) begin
                                r_state <= ST_LIT;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt - c_one;
                            end
                        end
                        ST_LIT: begin
                            if (ack[ch]) begin
                                r_state <= ST_ACKED;
                            end
                        end
                        ST_ACKED: begin
                            r_state <= ST_ACKED;
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end
                    endcase
                end
            end

            assign pending[ch] = (r_state == ST_LIT);
        end
    endgenerate

    assign light = pending & {CHANNELS{w_blink_gate}};

    // Fixed priority: scan downward so the lowest pending index is left last.
    always_comb begin
        grant_idx   = '0;
        grant_valid = |pending;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_canal_signal_lights.sv
`default_nettype none
// ============================================================================
// Module   : tb_canal_signal_lights
// Brief    : Directed bench with a run-length reference model for two configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_canal_signal_lights;

    localparam int HOLD_A = 16;
    localparam int HOLD_B = 3;
    localparam int BH_B   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sw_a = 2'b00, ack_a = 2'b00;
    logic [1:0] sw_b = 2'b00, ack_b = 2'b00;
    logic [1:0] light_a, pending_a, light_b, pending_b;
    logic       gv_a, gv_b;
    logic       gi_a, gi_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    canal_signal_lights #(.CHANNELS(2), .HOLD(HOLD_A), .BLINK_EN(0), .BLINK_HALF(8)) dut_a (
        .clk(clk), .reset(reset), .sw(sw_a), .ack(ack_a),
        .light(light_a), .pending(pending_a), .grant_valid(gv_a), .grant_idx(gi_a)
    );

    canal_signal_lights #(.CHANNELS(2), .HOLD(HOLD_B), .BLINK_EN(1), .BLINK_HALF(BH_B)) dut_b (
        .clk(clk), .reset(reset), .sw(sw_b), .ack(ack_b),
        .light(light_b), .pending(pending_b), .grant_valid(gv_b), .grant_idx(gi_b)
    );

    // Model: a channel is lit once its switch has been high for HOLD straight
    // samples, unless it was acknowledged while lit during this press.
    int run_m [2][2];
    bit ackd_m [2][2];
    int nedge;

    function automatic int hold_of(int d);
        return (d == 0) ? HOLD_A : HOLD_B;
    endfunction

    function automatic bit sw_bit(int d, int i);
        return (d == 0) ? sw_a[i] : sw_b[i];
    endfunction

    function automatic bit ack_bit(int d, int i);
        return (d == 0) ? ack_a[i] : ack_b[i];
    endfunction

    function automatic bit lit_m(int d, int i);
        return (run_m[d][i] >= hold_of(d)) && !ackd_m[d][i];
    endfunction

    function automatic logic [1:0] pend_m(int d);
        return {lit_m(d, 1), lit_m(d, 0)};
    endfunction

    function automatic logic [1:0] light_m(int d);
        bit phase;
        phase = ((nedge / BH_B) % 2) == 0;
        return (d == 0) ? pend_m(0) : (pend_m(1) & {2{phase}});
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 2; i++) begin
                    run_m[d][i]  <= 0;
                    ackd_m[d][i] <= 1'b0;
                end
            nedge <= 0;
        end else begin
            nedge <= nedge + 1;
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 2; i++) begin
                    if (!sw_bit(d, i)) begin
                        run_m[d][i]  <= 0;
                        ackd_m[d][i] <= 1'b0;
                    end else begin
                        run_m[d][i] <= (run_m[d][i] >= hold_of(d)) ? hold_of(d) : run_m[d][i] + 1;
                        if (lit_m(d, i) && ack_bit(d, i))
                            ackd_m[d][i] <= 1'b1;
                    end
                end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        begin : cmp
            logic [1:0] pa, pb;
            pa = pend_m(0);
            pb = pend_m(1);
            chk("cyc_light_a",   int'(light_a),   int'(light_m(0)));
            chk("cyc_pending_a", int'(pending_a), int'(pa));
            chk("cyc_gv_a",      int'(gv_a),      int'(|pa));
            chk("cyc_gi_a",      int'(gi_a),      (pa[0] || !pa[1]) ? 0 : 1);
            chk("cyc_light_b",   int'(light_b),   int'(light_m(1)));
            chk("cyc_pending_b", int'(pending_b), int'(pb));
            chk("cyc_gv_b",      int'(gv_b),      int'(|pb));
            chk("cyc_gi_b",      int'(gi_b),      (pb[0] || !pb[1]) ? 0 : 1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #1 reset = 1'b0;
        #2;
        chk("rst_light_a", int'(light_a), 0);
        chk("rst_pending_a", int'(pending_a), 0);
        chk("rst_gv_a", int'(gv_a), 0);
        chk("rst_gi_a", int'(gi_a), 0);
        chk("rst_light_b", int'(light_b), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sw_b  = 2'b01;

        // Blink config: lit after 3 edges, phase flips every 4 edges.
        step(3);
        chk("blink_lit_e3", int'(light_b), 1);
        chk("blink_pend_e3", int'(pending_b), 1);
        step(1);
        chk("blink_off_e4", int'(light_b), 0);
        chk("blink_pend_e4", int'(pending_b), 1);
        step(3);
        chk("blink_off_e7", int'(light_b), 0);
        step(1);
        chk("blink_on_e8", int'(light_b), 1);
        step(4);
        chk("blink_off_e12", int'(light_b), 0);
        @(negedge clk) ack_b = 2'b01;
        step(1);
        chk("blink_ack_pend", int'(pending_b), 0);
        chk("blink_ack_light", int'(light_b), 0);
        @(negedge clk) ack_b = 2'b00;
        step(3);
        chk("blink_acked_e16", int'(light_b), 0);
        @(negedge clk) sw_b = 2'b00;

        // Steady config, basic qualification.
        @(negedge clk) sw_a = 2'b01;
        step(15);
        chk("qual_e15", int'(light_a), 0);
        step(1);
        chk("qual_e16", int'(light_a), 1);
        chk("qual_pend", int'(pending_a), 1);
        chk("qual_gv", int'(gv_a), 1);
        chk("qual_gi", int'(gi_a), 0);

        // Ack clears and stays clear while held; re-press requalifies.
        @(negedge clk) ack_a = 2'b01;
        step(1);
        chk("ack_light", int'(light_a), 0);
        chk("ack_pend", int'(pending_a), 0);
        @(negedge clk) ack_a = 2'b00;
        step(40);
        chk("ack_held40", int'(light_a), 0);
        @(negedge clk) sw_a = 2'b00;
        step(1);
        @(negedge clk) sw_a = 2'b01;
        step(15);
        chk("repress_e15", int'(light_a), 0);
        step(1);
        chk("repress_e16", int'(light_a), 1);

        // Glitch restarts the count.
        @(negedge clk) sw_a = 2'b00;
        step(1);
        @(negedge clk) sw_a = 2'b01;
        step(10);
        @(negedge clk) sw_a = 2'b00;
        step(1);
        @(negedge clk) sw_a = 2'b01;
        step(15);
        chk("glitch_e15", int'(light_a), 0);
        step(1);
        chk("glitch_e16", int'(light_a), 1);

        // Ack during qualification is not remembered.
        @(negedge clk) sw_a = 2'b00;
        step(1);
        @(negedge clk) begin sw_a = 2'b01; ack_a = 2'b01; end
        step(5);
        @(negedge clk) ack_a = 2'b00;
        step(10);
        chk("earlyack_e15", int'(light_a), 0);
        step(1);
        chk("earlyack_e16", int'(pending_a), 1);

        // Arbiter with both lit.
        @(negedge clk) sw_a = 2'b11;
        step(16);
        chk("arb_pend11", int'(pending_a), 3);
        chk("arb_gi0", int'(gi_a), 0);
        @(negedge clk) ack_a = 2'b01;
        step(1);
        chk("arb_gi1", int'(gi_a), 1);
        chk("arb_gv1", int'(gv_a), 1);
        @(negedge clk) ack_a = 2'b10;
        step(1);
        chk("arb_gv0", int'(gv_a), 0);
        chk("arb_gi_none", int'(gi_a), 0);
        @(negedge clk) ack_a = 2'b00;

        // Asynchronous reset mid-LIT (a ch0, b ch0) and mid-QUAL (a ch1).
        @(negedge clk) begin sw_a = 2'b00; sw_b = 2'b00; end
        step(1);
        @(negedge clk) begin sw_a = 2'b01; sw_b = 2'b01; end
        step(20);
        @(negedge clk) sw_a = 2'b11;
        step(5);
        reset = 1'b0;
        #1;
        chk("arst_light_a", int'(light_a), 0);
        chk("arst_pend_a", int'(pending_a), 0);
        chk("arst_gv_a", int'(gv_a), 0);
        chk("arst_gi_a", int'(gi_a), 0);
        chk("arst_light_b", int'(light_b), 0);
        chk("arst_pend_b", int'(pending_b), 0);
        @(negedge clk) reset = 1'b1;
        step(15);
        chk("rel_e15", int'(light_a), 0);
        step(1);
        chk("rel_e16", int'(light_a), 3);
        chk("rel_b_light", int'(light_b), 1);
        chk("rel_b_pend", int'(pending_b), 1);

        @(negedge clk) begin sw_a = 2'b00; sw_b = 2'b00; end
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
